voice_alloc: RTL

VOICE_ALLOC -- requirements
Module: voice_alloc

---
 rtl/voice_alloc.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/voice_alloc.sv
// voice_alloc -- note-on/note-off voice allocator for a small tone-generator bank.
//
// Each accepted key message passes through a three-state FSM:
//   IDLE   : msg_ready high. An accepted message is registered here.
//   SEARCH : hit, lowest free and oldest voice are found against the registered
//            message. The decision takes effect on the edge that leaves SEARCH.
//   COMMIT : voice_trig/steal pulse for exactly this cycle, then back to IDLE.
// A voice is chosen in this order: a voice already holding the note
// (retrigger), the lowest-index free voice, or the least-recently started
// voice (steal). Recency is a 2-bit rank per voice: 0 is newest and
// NVOICE-1 is oldest.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   msg_valid, msg     key message: msg[7] 1=on/0=off, msg[6:0] note id
//   msg_ready          high only in IDLE
//   voice_on           per-voice active flag
//   voice_note         7-bit note per voice; voice i at [7i+6:7i]
//   voice_trig, steal  single-cycle pulses during COMMIT
//   active_cnt         population count of voice_on

module voice_slot #(
    parameter int            RW       = 2,
    parameter logic [RW-1:0] RST_RANK = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,   // note-on lands here: becomes newest
    input  logic          clear,  // note-off for the note held here
    input  logic          age,    // another voice was started: rank grows by one
    input  logic [6:0]    id,
    output logic          on,
    output logic [6:0]    note,
    output logic [RW-1:0] rank,
    output logic          hit
);
    always_ff @(posedge clk) begin
        if (rst) begin
            on   <= 1'b0;
            note <= 7'd0;
            rank <= RST_RANK;
        end else if (load) begin
            on   <= 1'b1;
            note <= id;
            rank <= '0;
        end else begin
            if (clear) on <= 1'b0;
            if (age)   rank <= rank + RW'(1);
        end
    end

    assign hit = on && (note == id);
endmodule

module voice_alloc #(
    parameter int NVOICE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  msg_valid,
    input  logic [7:0]            msg,
    output logic                  msg_ready,
    output logic [NVOICE-1:0]     voice_on,
    output logic [7*NVOICE-1:0]   voice_note,
    output logic [NVOICE-1:0]     voice_trig,
    output logic                  steal,
    output logic [2:0]            active_cnt
);
    localparam int IW = $clog2(NVOICE);

    typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;

    state_t                     state;
    logic [7:0]                 msg_r;
    logic [NVOICE-1:0]          on_vec, hit_vec, load, clear, age, next_on;
    logic [NVOICE-1:0][6:0]     note_arr;
    logic [NVOICE-1:0][IW-1:0]  rank_arr;
    logic                       hit_any, free_any, in_search, is_on, on_commit, do_steal;
    logic [IW-1:0]              hit_idx, free_idx, old_idx, tgt;
    logic [6:0]                 id;
    logic [2:0]                 cnt_next;

    assign msg_ready  = (state == IDLE);
    assign voice_on   = on_vec;
    assign voice_note = note_arr;

    assign in_search = (state == SEARCH);
    assign is_on     = msg_r[7];
    assign id        = msg_r[6:0];
    // Note id 0 is silence: a note-on for it must not touch any voice.
    assign on_commit = in_search && is_on && (id != 7'd0);

    // Scanning downward lets the lowest index win for hit and free.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        old_idx  = '0;
        for (int i = NVOICE - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
            if (!on_vec[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
            if (rank_arr[i] == IW'(NVOICE - 1)) old_idx = IW'(i);
        end
    end

    assign tgt      = hit_any ? hit_idx : (free_any ? free_idx : old_idx);
    assign do_steal = on_commit && !hit_any && !free_any;

    // Ranks below the target's old rank shift up by one; the target goes to 0.
    // This keeps the ranks a permutation without any renormalisation.
    always_comb begin
        load  = '0;
        clear = '0;
        age   = '0;
        for (int i = 0; i < NVOICE; i++) begin
            load[i]  = on_commit && (tgt == IW'(i));
            age[i]   = on_commit && (rank_arr[i] < rank_arr[tgt]);
            clear[i] = in_search && !is_on && hit_vec[i];
        end
    end

    // active_cnt is registered from the same next-state as voice_on, so the
    // two always change on the same edge.
    assign next_on = (on_vec & ~clear) | load;
    always_comb begin
        cnt_next = 3'd0;
        for (int i = 0; i < NVOICE; i++) cnt_next = cnt_next + 3'(next_on[i]);
    end

    for (genvar g = 0; g < NVOICE; g++) begin : g_voice
        voice_slot #(
            .RW       (IW),
            .RST_RANK (IW'(g))
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[g]),
            .clear (clear[g]),
            .age   (age[g]),
            .id    (id),
            .on    (on_vec[g]),
            .note  (note_arr[g]),
            .rank  (rank_arr[g]),
            .hit   (hit_vec[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            msg_r      <= 8'd0;
            voice_trig <= '0;
            steal      <= 1'b0;
            active_cnt <= 3'd0;
        end else begin
            active_cnt <= cnt_next;
            case (state)
                IDLE: begin
                    voice_trig <= '0;
                    steal      <= 1'b0;
                    if (msg_valid) begin
                        msg_r <= msg;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    voice_trig <= load;
                    steal      <= do_steal;
                    state      <= COMMIT;
                end
                COMMIT: begin
                    voice_trig <= '0;
                    steal      <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    voice_trig <= '0;
                    steal      <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule
